// File: rtl/ctrl_pipe.sv
// ctrl_pipe: MIPS 5-stage control decode plus ID/EX, EX/MEM, MEM/WB control registers.
// Define CTRL_HAZARD_EN to include the load-use hazard detector.
module ctrl_pipe #(
  parameter int REG_AW = 5,
  parameter int ALUC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_id,
  input  logic              id_valid,
  input  logic              stall_ext,
  input  logic              flush,
  output logic              hazard_stall,
  output logic [1:0]        id_ex_wb,
  output logic [2:0]        id_ex_m,
  output logic [3:0]        id_ex_ex,
  output logic [ALUC_W-1:0] id_ex_aluc,
  output logic [REG_AW-1:0] id_ex_rs,
  output logic [REG_AW-1:0] id_ex_rt,
  output logic [REG_AW-1:0] id_ex_rd,
  output logic [1:0]        ex_mem_wb,
  output logic [2:0]        ex_mem_m,
  output logic [1:0]        mem_wb_wb,
  output logic              illegal_op
);
  typedef struct packed {
    logic [1:0]        wb;
    logic [2:0]        m;
    logic [3:0]        ex;
    logic [ALUC_W-1:0] aluc;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic              ill;
  } idex_t;
  idex_t             dec, id_ex_d, id_ex_q;
  logic [4:0]        ex_mem_d, ex_mem_q;
  logic [1:0]        mem_wb_d, mem_wb_q;
  logic [5:0]        op, funct;
  logic              f_ok, hz;
  logic [ALUC_W-1:0] f_code;
  assign op    = instr_id[31:26];
  assign funct = instr_id[5:0];
  always_comb begin
    f_ok   = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    f_code = funct == 6'h20 ? ALUC_W'(4'b0010) :
             funct == 6'h22 ? ALUC_W'(4'b0110) :
             funct == 6'h25 ? ALUC_W'(4'b0001) :
             funct == 6'h2A ? ALUC_W'(4'b0111) : '0;
  end
  always_comb begin
    dec    = '0;
    dec.rs = REG_AW'(instr_id[25:21]);
    dec.rt = REG_AW'(instr_id[20:16]);
    dec.rd = REG_AW'(instr_id[15:11]);
    if (id_valid) begin
      case (op)
        6'h00: begin
          // the all-zero word (sll $0) is a legal NOP, other unknown functs are not
          dec.ill = (instr_id != '0) && !f_ok;
          if (f_ok) {dec.wb, dec.m, dec.ex} = 9'b10_000_1100;
        end
        6'h23:   {dec.wb, dec.m, dec.ex} = 9'b11_010_0001;
        6'h2B:   {dec.wb, dec.m, dec.ex} = 9'b00_001_0001;
        6'h04:   {dec.wb, dec.m, dec.ex} = 9'b00_100_0010;
        6'h08:   {dec.wb, dec.m, dec.ex} = 9'b10_000_0001;
        default: dec.ill = 1'b1;
      endcase
    end
    dec.aluc = dec.ex[2:1] == 2'b10 ? f_code :
               dec.ex[2:1] == 2'b01 ? ALUC_W'(4'b0110) :
               dec.ex != '0         ? ALUC_W'(4'b0010) : '0;
  end
`ifdef CTRL_HAZARD_EN
  logic uses_rt;
  assign uses_rt = op == 6'h00 || op == 6'h2B || op == 6'h04;
  assign hz = !rst && !stall_ext && !flush && id_valid && id_ex_q.m[1] && id_ex_q.rt != '0 &&
              (id_ex_q.rt == dec.rs || (uses_rt && id_ex_q.rt == dec.rt));
`else
  assign hz = 1'b0;
`endif
  assign hazard_stall = hz;
  always_comb begin
    id_ex_d  = flush ? '0 : stall_ext ? id_ex_q : hz ? '0 : dec;
    ex_mem_d = flush ? '0 : stall_ext ? ex_mem_q : {id_ex_q.wb, id_ex_q.m};
    mem_wb_d = (stall_ext && !flush) ? mem_wb_q : ex_mem_q[4:3];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end
  assign id_ex_wb   = id_ex_q.wb;
  assign id_ex_m    = id_ex_q.m;
  assign id_ex_ex   = id_ex_q.ex;
  assign id_ex_aluc = id_ex_q.aluc;
  assign id_ex_rs   = id_ex_q.rs;
  assign id_ex_rt   = id_ex_q.rt;
  assign id_ex_rd   = id_ex_q.rd;
  assign illegal_op = id_ex_q.ill;
  assign ex_mem_wb  = ex_mem_q[4:3];
  assign ex_mem_m   = ex_mem_q[2:0];
  assign mem_wb_wb  = mem_wb_q;
endmodule
